// File: rtl/decoder_host_link_if.sv
// ---------------------------------------------------------------------------
// decoder_host_link_if
// Byte link between the host endpoint and the decoder controller.
//   tx_data/tx_valid/tx_ready : host -> controller byte stream
//   rx_data/rx_valid/rx_ready : controller -> host byte stream
// Modports:
//   master : host endpoint (drives tx, sinks rx)
//   slave  : controller side (sinks tx, drives rx)
// ---------------------------------------------------------------------------
interface decoder_host_link_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/decoder_host_link.sv
// ---------------------------------------------------------------------------
// decoder_host_link
// Host-side endpoint of the decoder byte link. Serializes one syndrome job
// (start byte, header byte, measurement bytes) towards the controller and
// reassembles the controller's reply (iterations, cycle count, correction
// bytes) into one wide result word. One job in flight at a time.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-low reset
//   job_syndrome      PR*U bits, round r at [r*PR +: PR]
//   job_valid/ready   job handshake (ready only in IDLE)
//   link              byte link (master modport): tx towards controller,
//                     rx from controller
//   result_iterations grow iterations reported
//   result_cycles     cycle count reported
//   result_correction CW*U bits, round r at [r*CW +: CW]
//   result_valid/ready result handshake, result held until accepted
//   timeout_error     sticky watchdog flag
//
// Optional feature: define HOST_LINK_TIMEOUT_EN to enable the link watchdog.
// Without it timeout_error is tied low and the link waits indefinitely.
// ---------------------------------------------------------------------------
module decoder_host_link #(
    parameter int unsigned GRID_WIDTH_X   = 4,
    parameter int unsigned GRID_WIDTH_Z   = 1,
    parameter int unsigned GRID_WIDTH_U   = 3,
    parameter logic [7:0]  START_MSG      = 8'h00,
    parameter logic [7:0]  HEADER_MSG     = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] job_syndrome,
    input  logic job_valid,
    output logic job_ready,
    decoder_host_link_if.master link,
    output logic [7:0]  result_iterations,
    output logic [15:0] result_cycles,
    output logic [(2*(GRID_WIDTH_X-1)*GRID_WIDTH_Z+1+GRID_WIDTH_X*GRID_WIDTH_Z)*GRID_WIDTH_U-1:0] result_correction,
    output logic result_valid,
    input  logic result_ready,
    output logic timeout_error
);

    localparam int unsigned PR   = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int unsigned MB   = (PR + 7) / 8;
    localparam int unsigned CW   = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1 + GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int unsigned CB   = (CW + 7) / 8;
    localparam int unsigned U    = GRID_WIDTH_U;
    localparam int unsigned SW   = PR * U;
    localparam int unsigned CWU  = CW * U;
    localparam int unsigned MBW  = MB * 8;
    localparam int unsigned MAXB = (MB > CB) ? MB : CB;
    localparam int unsigned BW   = $clog2(MAXB) + 1;
    localparam int unsigned RW   = $clog2(U) + 1;

    localparam logic [BW-1:0]  LAST_MB    = BW'(MB - 1);
    localparam logic [BW-1:0]  LAST_CB    = BW'(CB - 1);
    localparam logic [RW-1:0]  LAST_RND   = RW'(U - 1);
    localparam logic [CWU-1:0] ROUND_ONES = CWU'({CW{1'b1}});

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_HEADER, TX_MEAS,
        RX_ITER, RX_CYC_HI, RX_CYC_LO, RX_CORR, RESULT
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [SW-1:0]   syn_q, syn_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      iter_q, iter_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [CWU-1:0]  corr_q, corr_d;
    logic            tx_fire, rx_fire;
    logic [31:0]     corr_sh;
    logic [CWU-1:0]  corr_mask;

    // Byte b of round r, bits beyond PR read as zero.
    function automatic logic [7:0] meas_byte(input logic [SW-1:0] syn,
                                             input logic [RW-1:0] r,
                                             input logic [BW-1:0] b);
        logic [PR-1:0]  rbits;
        logic [MBW-1:0] ext;
        rbits = PR'(syn >> (32'(r) * PR));
        ext   = MBW'(rbits);
        return 8'(ext >> (32'(b) * 8));
    endfunction

    assign link.rx_ready = (state_q == RX_ITER) || (state_q == RX_CYC_HI) ||
                           (state_q == RX_CYC_LO) || (state_q == RX_CORR);
    assign link.tx_data  = tx_data_q;
    assign link.tx_valid = tx_valid_q;
    assign job_ready     = (state_q == IDLE) && reset;
    assign result_valid  = (state_q == RESULT);
    assign result_iterations = iter_q;
    assign result_cycles     = cyc_q;
    assign result_correction = corr_q;

    assign tx_fire = tx_valid_q && link.tx_ready;
    assign rx_fire = link.rx_ready && link.rx_valid;

`ifdef HOST_LINK_TIMEOUT_EN
    localparam int unsigned     WDW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           to_q, to_d;
    assign timeout_error = to_q;
`else
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        rnd_d      = rnd_q;
        syn_d      = syn_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        iter_d     = iter_q;
        cyc_d      = cyc_q;
        corr_d     = corr_q;
        // Correction byte lands at r*CW + 8b; the mask clips it to its round.
        corr_sh    = 32'(rnd_q) * CW + 32'(byte_q) * 8;
        corr_mask  = (CWU'(8'hFF) << corr_sh) & (ROUND_ONES << (32'(rnd_q) * CW));

        unique case (state_q)
            IDLE: begin
                if (job_valid) begin
                    syn_d      = job_syndrome;
                    tx_valid_d = 1'b1;
                    tx_data_d  = START_MSG;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (tx_fire) begin
                    tx_data_d = HEADER_MSG;
                    state_d   = TX_HEADER;
                end
            end
            TX_HEADER: begin
                if (tx_fire) begin
                    tx_data_d = meas_byte(syn_q, '0, '0);
                    state_d   = TX_MEAS;
                end
            end
            TX_MEAS: begin
                if (tx_fire) begin
                    if (byte_q == LAST_MB) begin
                        byte_d = '0;
                        rnd_d  = rnd_q + RW'(1);
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                    if (byte_q == LAST_MB && rnd_q == LAST_RND) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        state_d    = RX_ITER;
                    end else begin
                        tx_data_d = meas_byte(syn_q, rnd_d, byte_d);
                    end
                end
            end
            RX_ITER: begin
                if (rx_fire) begin
                    iter_d  = link.rx_data;
                    state_d = RX_CYC_HI;
                end
            end
            RX_CYC_HI: begin
                if (rx_fire) begin
                    cyc_d[15:8] = link.rx_data;
                    state_d     = RX_CYC_LO;
                end
            end
            RX_CYC_LO: begin
                if (rx_fire) begin
                    cyc_d[7:0] = link.rx_data;
                    state_d    = RX_CORR;
                end
            end
            RX_CORR: begin
                if (rx_fire) begin
                    corr_d = (corr_q & ~corr_mask) | ((CWU'(link.rx_data) << corr_sh) & corr_mask);
                    if (byte_q == LAST_CB) begin
                        byte_d = '0;
                        rnd_d  = rnd_q + RW'(1);
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                    if (byte_q == LAST_CB && rnd_q == LAST_RND)
                        state_d = RESULT;
                end
            end
            RESULT: begin
                if (result_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef HOST_LINK_TIMEOUT_EN
        wd_d = wd_q;
        to_d = to_q;
        if (state_q != IDLE && state_q != RESULT) begin
            if (tx_fire || rx_fire) begin
                wd_d = '0;
            end else if (wd_q == WD_LAST) begin
                // Abandon the job: no result is presented.
                wd_d       = '0;
                to_d       = 1'b1;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
                state_d    = IDLE;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end else begin
            wd_d = '0;
        end
`endif

        // Position counters restart on every state entry.
        if (state_d != state_q) begin
            byte_d = '0;
            rnd_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            rnd_q      <= '0;
            syn_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            iter_q     <= '0;
            cyc_q      <= '0;
            corr_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            rnd_q      <= rnd_d;
            syn_q      <= syn_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            iter_q     <= iter_d;
            cyc_q      <= cyc_d;
            corr_q     <= corr_d;
        end
    end

`ifdef HOST_LINK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_host_link.sv
// ---------------------------------------------------------------------------
// tb_decoder_host_link
// Self-checking bench for decoder_host_link (default build, watchdog off).
// Hand-filled vector table for known jobs, then random jobs whose expected
// byte stream and result come from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_decoder_host_link;

    localparam int PR  = 4;
    localparam int U   = 3;
    localparam int CW  = 11;
    localparam int MB  = 1;
    localparam int CB  = 2;
    localparam int NTX = 2 + MB * U;
    localparam int NRX = 3 + CB * U;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] job_syndrome;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  result_iterations;
    logic [15:0] result_cycles;
    logic [32:0] result_correction;
    logic        result_valid;
    logic        result_ready;
    logic        timeout_error;

    always #5 clk = ~clk;

    decoder_host_link_if link();

    decoder_host_link #(
        .GRID_WIDTH_X (4),
        .GRID_WIDTH_Z (1),
        .GRID_WIDTH_U (3),
        .START_MSG    (8'h00),
        .HEADER_MSG   (8'h01)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .job_syndrome      (job_syndrome),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .link              (link.master),
        .result_iterations (result_iterations),
        .result_cycles     (result_cycles),
        .result_correction (result_correction),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .timeout_error     (timeout_error)
    );

    typedef struct packed {
        logic [11:0]           syn;
        logic [0:8][7:0]       rx;
        logic [0:4][7:0]       tx;
        logic [7:0]            iter;
        logic [15:0]           cyc;
        logic [0:2][10:0]      rnd;
        logic [1:0]            tx_mode;
        logic [3:0]            stall;
    } vec_t;

    vec_t vecs [4];

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0]     cur_syn;
    logic [0:8][7:0] cur_rx;
    logic [0:4][7:0] cur_tx;
    logic [7:0]      cur_iter;
    logic [15:0]     cur_cyc;
    logic [32:0]     cur_corr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected traffic computed from the job with plain arithmetic.
    task automatic model_build();
        longint acc;
        longint word;
        longint rv;
        cur_tx[0] = 8'h00;
        cur_tx[1] = 8'h01;
        for (int r = 0; r < U; r++) begin
            rv = (longint'(cur_syn) >> (r * PR)) % (longint'(1) << PR);
            for (int b = 0; b < MB; b++)
                cur_tx[2 + r * MB + b] = 8'((rv >> (8 * b)) % 256);
        end
        cur_iter = cur_rx[0];
        cur_cyc  = 16'(int'(cur_rx[1]) * 256 + int'(cur_rx[2]));
        acc = 0;
        for (int r = 0; r < U; r++) begin
            word = 0;
            for (int b = 0; b < CB; b++)
                word += longint'(cur_rx[3 + r * CB + b]) << (8 * b);
            word = word % (longint'(1) << CW);
            acc += word << (r * CW);
        end
        cur_corr = 33'(acc);
    endtask

    task automatic run_job(input int tx_mode, input int rx_mode, input int res_stall, input int abort_after);
        int   n, m, cyc;
        logic r, stalled;
        logic [7:0] held;

        check("job_ready_idle", 64'(job_ready), 64'd1);
        job_syndrome = cur_syn;
        job_valid    = 1'b1;
        @(negedge clk);
        job_valid    = 1'b0;
        job_syndrome = 12'($urandom);
        check("rx_ready_in_tx", 64'(link.rx_ready), 64'd0);

        n = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (n < NTX && cyc < 200) begin
            if (stalled) begin
                check("tx_valid_held", 64'(link.tx_valid), 64'd1);
                check("tx_data_held", 64'(link.tx_data), 64'(held));
            end
            case (tx_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom % 2);
            endcase
            link.tx_ready = r;
            if (link.tx_valid && r) begin
                check($sformatf("tx_byte%0d", n), 64'(link.tx_data), 64'(cur_tx[n]));
                n++;
            end
            stalled = link.tx_valid && !r;
            held    = link.tx_data;
            @(negedge clk);
            cyc++;
        end
        link.tx_ready = 1'b0;
        if (n < NTX) check("tx_bytes_timeout", 64'(n), 64'(NTX));
        if (tx_mode == 0) check("tx_cycles", 64'(cyc), 64'(NTX));
        check("tx_valid_after_tx", 64'(link.tx_valid), 64'd0);
        check("rx_ready_after_tx", 64'(link.rx_ready), 64'd1);

        m = 0; cyc = 0;
        while (m < NRX && m < abort_after && cyc < 200) begin
            r = (rx_mode == 0) ? 1'b1 : 1'($urandom % 2);
            link.rx_valid = r;
            link.rx_data  = r ? cur_rx[m] : 8'($urandom);
            if (r && link.rx_ready) m++;
            @(negedge clk);
            cyc++;
        end
        link.rx_valid = 1'b0;
        if (m < NRX && m < abort_after) check("rx_bytes_timeout", 64'(m), 64'(NRX));
        if (abort_after < NRX) return;
        if (rx_mode == 0) check("rx_cycles", 64'(cyc), 64'(NRX));

        check("result_valid", 64'(result_valid), 64'd1);
        check("result_iterations", 64'(result_iterations), 64'(cur_iter));
        check("result_cycles", 64'(result_cycles), 64'(cur_cyc));
        check("result_correction", 64'(result_correction), 64'(cur_corr));

        for (int k = 0; k < res_stall; k++) begin
            result_ready  = 1'b0;
            job_valid     = 1'b1;
            link.rx_valid = 1'b1;
            link.rx_data  = 8'($urandom);
            @(negedge clk);
            check("stall_result_valid", 64'(result_valid), 64'd1);
            check("stall_rx_ready", 64'(link.rx_ready), 64'd0);
            check("stall_job_ready", 64'(job_ready), 64'd0);
            check("stall_correction", 64'(result_correction), 64'(cur_corr));
            check("stall_cycles", 64'(result_cycles), 64'(cur_cyc));
        end
        job_valid     = 1'b0;
        link.rx_valid = 1'b0;
        result_ready  = 1'b1;
        @(negedge clk);
        result_ready  = 1'b0;
        check("release_result_valid", 64'(result_valid), 64'd0);
        check("release_job_ready", 64'(job_ready), 64'd1);
    endtask

    task automatic load_vec(input int i);
        cur_syn  = vecs[i].syn;
        cur_rx   = vecs[i].rx;
        cur_tx   = vecs[i].tx;
        cur_iter = vecs[i].iter;
        cur_cyc  = vecs[i].cyc;
        cur_corr = {vecs[i].rnd[2], vecs[i].rnd[1], vecs[i].rnd[0]};
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{syn: 12'hA53,
                    rx: {8'h07, 8'h01, 8'h2C, 8'hFF, 8'h07, 8'h34, 8'h02, 8'h80, 8'h05},
                    tx: {8'h00, 8'h01, 8'h03, 8'h05, 8'h0A},
                    iter: 8'h07, cyc: 16'h012C,
                    rnd: {11'h7FF, 11'h234, 11'h580}, tx_mode: 2'd0, stall: 4'd10};
        vecs[1] = vecs[0];
        vecs[1].tx_mode = 2'd1;
        vecs[1].stall   = 4'd0;
        vecs[2] = '{syn: 12'h0FF,
                    rx: {8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h34},
                    tx: {8'h00, 8'h01, 8'h0F, 8'h0F, 8'h00},
                    iter: 8'h00, cyc: 16'hFFFF,
                    rnd: {11'h000, 11'h7FF, 11'h412}, tx_mode: 2'd0, stall: 4'd2};
        vecs[3] = '{syn: 12'h1E7,
                    rx: {8'h80, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h55, 8'hAA, 8'h01, 8'h00},
                    tx: {8'h00, 8'h01, 8'h07, 8'h0E, 8'h01},
                    iter: 8'h80, cyc: 16'h1234,
                    rnd: {11'h5AB, 11'h255, 11'h001}, tx_mode: 2'd2, stall: 4'd1};

        reset         = 1'b0;
        job_syndrome  = '0;
        job_valid     = 1'b0;
        result_ready  = 1'b0;
        link.tx_ready = 1'b0;
        link.rx_valid = 1'b0;
        link.rx_data  = '0;

        repeat (2) @(negedge clk);
        check("rst_job_ready", 64'(job_ready), 64'd0);
        check("rst_tx_valid", 64'(link.tx_valid), 64'd0);
        check("rst_tx_data", 64'(link.tx_data), 64'd0);
        check("rst_rx_ready", 64'(link.rx_ready), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result_correction", 64'(result_correction), 64'd0);
        check("rst_result_cycles", 64'(result_cycles), 64'd0);
        check("rst_timeout_error", 64'(timeout_error), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_job(int'(vecs[i].tx_mode), 0, int'(vecs[i].stall), NRX);
        end

        // Reset mid-job while correction byte 3 is pending.
        load_vec(2);
        run_job(0, 0, 0, 6);
        link.rx_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("midrst_job_ready", 64'(job_ready), 64'd0);
        check("midrst_rx_ready", 64'(link.rx_ready), 64'd0);
        check("midrst_tx_valid", 64'(link.tx_valid), 64'd0);
        check("midrst_result_valid", 64'(result_valid), 64'd0);
        check("midrst_iterations", 64'(result_iterations), 64'd0);
        check("midrst_cycles", 64'(result_cycles), 64'd0);
        check("midrst_correction", 64'(result_correction), 64'd0);
        link.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_vec(0);
        run_job(0, 0, 0, NRX);

        // Random jobs against the reference model.
        for (int t = 0; t < 25; t++) begin
            cur_syn = 12'($urandom);
            for (int k = 0; k < NRX; k++) cur_rx[k] = 8'($urandom);
            model_build();
            run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), NRX);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
